// File: rtl/noc_pkg.sv
// Flit field positions and a width helper shared by the router and its FIFOs.
package noc_pkg;

    localparam int unsigned VALID_BIT = 0;
    localparam int unsigned DEST_LSB  = 1;

    // Ceiling log2. The result is never below 1, so a one-port-index field still has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Per-port input FIFO. Full and almost-full come only from the registered count.
module noc_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AF_LEVEL   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              almost_full
);

    localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = ((32'(count_q) + AF_LEVEL) >= FIFO_DEPTH);
    // A pop in the same cycle never makes room for a write to a full FIFO.
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign head        = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is a power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/noc_router_rr.sv
// Input-queued crossbar router with a round-robin arbiter and a register per output.
module noc_router_rr
    import noc_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AF_LEVEL   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          in_full,
    output logic [NUM_PORTS-1:0]          in_almost_full,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS-1:0]          bad_dest
);

    localparam int unsigned DEST_W = clog2(NUM_PORTS);

    logic [DATA_W-1:0]              head      [NUM_PORTS];
    logic [DEST_W-1:0]              head_dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]           req       [NUM_PORTS];  // req[input][output]
    logic [NUM_PORTS-1:0]           empty, pop, discard, bad_d, bad_q;
    logic [NUM_PORTS-1:0]           out_valid_d, out_valid_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_data_d, out_data_q;
    logic [DEST_W-1:0]              rr_d [NUM_PORTS];
    logic [DEST_W-1:0]              rr_q [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        noc_fifo #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH),
            .AF_LEVEL  (AF_LEVEL)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push       (in_valid[p]),
            .wdata      (in_data[p*DATA_W +: DATA_W]),
            .pop        (pop[p]),
            .head       (head[p]),
            .empty      (empty[p]),
            .full       (in_full[p]),
            .almost_full(in_almost_full[p])
        );
        assign head_dest[p] = head[p][DEST_LSB +: DEST_W];
    end

    // Sort each head into a routing request, a silent drop, or a bad-destination drop.
    always_comb begin
        discard = '0;
        bad_d   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req[i] = '0;
            if (!empty[i]) begin
                if (!head[i][VALID_BIT]) begin
                    discard[i] = 1'b1;
                end else if (32'(head_dest[i]) >= NUM_PORTS) begin
                    discard[i] = 1'b1;
                    bad_d[i]   = 1'b1;
                end else begin
                    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                        req[i][o] = (32'(head_dest[i]) == o);
                    end
                end
            end
        end
    end

    // Per-output round-robin grant, pop selection and output register next state.
    always_comb begin
        logic              found;
        logic [DEST_W-1:0] cand;
        logic [DEST_W-1:0] win;
        found       = 1'b0;
        cand        = '0;
        win         = '0;
        pop         = discard;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            rr_d[o] = rr_q[o];
            if (!out_valid_q[o] || out_ready[o]) begin
                out_valid_d[o] = 1'b0;
                found          = 1'b0;
                win            = '0;
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    cand = DEST_W'((32'(rr_q[o]) + k) % NUM_PORTS);
                    if (!found && req[cand][o]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                // Each input requests a single output, so at most one pop per FIFO.
                if (found) begin
                    pop[win]       = 1'b1;
                    out_valid_d[o] = 1'b1;
                    out_data_d[o]  = head[win];
                    rr_d[o]        = DEST_W'((32'(win) + 1) % NUM_PORTS);
                end
            end
        end
    end

    // Output registers, arbiter pointers and the bad-destination pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            bad_q       <= '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                rr_q[o] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            bad_q       <= bad_d;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                rr_q[o] <= rr_d[o];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign bad_dest  = bad_q;

endmodule

// File: tb/tb_noc_router_rr.sv
// Bench for noc_router_rr: directed table, backpressure and reset sequences, random traffic.
module tb_noc_router_rr;

    localparam int DEPTH = 4;
    localparam int AF    = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_valid, in_full, in_almost_full, out_valid, out_ready, bad_dest;
    logic [47:0] in_data, out_data;

    noc_router_rr #(
        .NUM_PORTS (3),
        .DATA_W    (16),
        .FIFO_DEPTH(DEPTH),
        .AF_LEVEL  (AF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_full       (in_full),
        .in_almost_full(in_almost_full),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .bad_dest      (bad_dest)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: one queue per input, plus output contents and arbiter pointers.
    logic [15:0] mq [3][$];
    logic [2:0]  m_ov, m_bad;
    logic [15:0] m_od [3];
    int          m_rr [3];

    task automatic model_step(input logic rst, input logic [2:0] vld, input logic [47:0] data,
                              input logic [2:0] rdy);
        logic [2:0]  popm, acc, nov, nbad;
        logic [15:0] h;
        int          i;
        bit          got;
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                mq[p].delete();
                m_od[p] = '0;
                m_rr[p] = 0;
            end
            m_ov  = '0;
            m_bad = '0;
        end else begin
            popm = '0;
            nbad = '0;
            nov  = m_ov;
            for (int p = 0; p < 3; p++) begin
                acc[p] = vld[p] && (mq[p].size() < DEPTH);
                if (mq[p].size() > 0) begin
                    h = mq[p][0];
                    if (!h[0]) begin
                        popm[p] = 1'b1;
                    end else if (int'(h[2:1]) >= 3) begin
                        popm[p] = 1'b1;
                        nbad[p] = 1'b1;
                    end
                end
            end
            for (int o = 0; o < 3; o++) begin
                if (!m_ov[o] || rdy[o]) begin
                    nov[o] = 1'b0;
                    got    = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        i = (m_rr[o] + k) % 3;
                        if (!got && mq[i].size() > 0) begin
                            h = mq[i][0];
                            if (h[0] && int'(h[2:1]) == o) begin
                                got     = 1'b1;
                                popm[i] = 1'b1;
                                nov[o]  = 1'b1;
                                m_od[o] = h;
                                m_rr[o] = (i + 1) % 3;
                            end
                        end
                    end
                end
            end
            m_ov  = nov;
            m_bad = nbad;
            for (int p = 0; p < 3; p++) begin
                if (popm[p]) void'(mq[p].pop_front());
                if (acc[p]) mq[p].push_back(data[p*16 +: 16]);
            end
        end
    endtask

    function automatic void check_model(string tag);
        logic [47:0] eod;
        logic [2:0]  ef, eaf;
        eod = {m_od[2], m_od[1], m_od[0]};
        for (int p = 0; p < 3; p++) begin
            ef[p]  = (mq[p].size() == DEPTH);
            eaf[p] = ((DEPTH - mq[p].size()) <= AF);
        end
        n_vec++;
        if (out_valid !== m_ov || out_data !== eod || bad_dest !== m_bad ||
            in_full !== ef || in_almost_full !== eaf) begin
            n_miss++;
            $display("FAIL model %s: got ov=%b od=%h bad=%b full=%b af=%b, want ov=%b od=%h bad=%b full=%b af=%b",
                     tag, out_valid, out_data, bad_dest, in_full, in_almost_full,
                     m_ov, eod, m_bad, ef, eaf);
        end
    endfunction

    function automatic void chk(string name, logic [47:0] act, logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // One clock: drive, advance model at the edge, compare 1 time unit later.
    task automatic step(input logic rst, input logic [2:0] vld, input logic [47:0] data,
                        input logic [2:0] rdy, input string tag);
        reset     = rst;
        in_valid  = vld;
        in_data   = data;
        out_ready = rdy;
        @(posedge clk);
        model_step(rst, vld, data, rdy);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  vld;
        logic [47:0] data;
        logic [2:0]  rdy;
        logic [2:0]  e_ov;
        logic [47:0] e_od;
        logic [2:0]  e_bad;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [2:0] vld, logic [47:0] data, logic [2:0] rdy,
                                logic [2:0] e_ov, logic [47:0] e_od, logic [2:0] e_bad);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data; v.rdy = rdy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_bad = e_bad;
        return v;
    endfunction

    vec_t tbl [24];

    initial begin
        logic [47:0] mask, d;
        logic [5:0]  exp_af, exp_full;
        logic [15:0] f;
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 3'b111;

        // Expectations hold after the edge at which the row's inputs are applied.
        tbl[0]  = mk(1, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[1]  = mk(0, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[2]  = mk(0, 3'b001, {16'h0, 16'h0, 16'h0003}, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[3]  = mk(0, 3'b000, 48'h0, 3'b111, 3'b010, {16'h0, 16'h0003, 16'h0}, 3'b000);
        tbl[4]  = mk(0, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[5]  = mk(0, 3'b111, {16'h0205, 16'h0105, 16'h0005}, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[6]  = mk(0, 3'b000, 48'h0, 3'b111, 3'b100, {16'h0005, 32'h0}, 3'b000);
        tbl[7]  = mk(0, 3'b000, 48'h0, 3'b111, 3'b100, {16'h0105, 32'h0}, 3'b000);
        tbl[8]  = mk(0, 3'b000, 48'h0, 3'b111, 3'b100, {16'h0205, 32'h0}, 3'b000);
        tbl[9]  = mk(0, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[10] = mk(0, 3'b101, {16'h0007, 16'h0, 16'h0002}, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[11] = mk(0, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b100);
        tbl[12] = mk(0, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b000);
        // Repeat contention: port 0 must win first, showing the pointer returned to 0.
        tbl[13] = mk(0, 3'b111, {16'h3305, 16'h2205, 16'h1105}, 3'b111, 3'b000, 48'h0, 3'b000);
        tbl[14] = mk(0, 3'b000, 48'h0, 3'b111, 3'b100, {16'h1105, 32'h0}, 3'b000);
        tbl[15] = mk(0, 3'b000, 48'h0, 3'b111, 3'b100, {16'h2205, 32'h0}, 3'b000);
        tbl[16] = mk(0, 3'b000, 48'h0, 3'b111, 3'b100, {16'h3305, 32'h0}, 3'b000);
        tbl[17] = mk(0, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b000);
        // Head-of-line: output 0 stalled, port 1 still reaches output 2.
        tbl[18] = mk(0, 3'b001, {32'h0, 16'h0101}, 3'b110, 3'b000, 48'h0, 3'b000);
        tbl[19] = mk(0, 3'b001, {32'h0, 16'h0201}, 3'b110, 3'b001, {32'h0, 16'h0101}, 3'b000);
        tbl[20] = mk(0, 3'b010, {16'h0, 16'h0005, 16'h0}, 3'b110, 3'b001, {32'h0, 16'h0101},
                     3'b000);
        tbl[21] = mk(0, 3'b000, 48'h0, 3'b110, 3'b101, {16'h0005, 16'h0, 16'h0101}, 3'b000);
        tbl[22] = mk(0, 3'b000, 48'h0, 3'b111, 3'b001, {32'h0, 16'h0201}, 3'b000);
        tbl[23] = mk(0, 3'b000, 48'h0, 3'b111, 3'b000, 48'h0, 3'b000);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].rdy, $sformatf("tbl%0d", i));
            for (int p = 0; p < 3; p++) mask[p*16 +: 16] = {16{tbl[i].e_ov[p]}};
            chk($sformatf("tbl%0d out_valid", i), 48'(out_valid), 48'(tbl[i].e_ov));
            chk($sformatf("tbl%0d bad_dest", i), 48'(bad_dest), 48'(tbl[i].e_bad));
            chk($sformatf("tbl%0d out_data", i), out_data & mask, tbl[i].e_od & mask);
        end

        // Backpressure: six writes to a stalled output, five flits come out back-to-back.
        exp_af   = 6'b111000;
        exp_full = 6'b110000;
        for (int j = 0; j < 6; j++) begin
            f = 16'((j + 1) << 12) | 16'h0001;
            step(0, 3'b010, {16'h0, f, 16'h0}, 3'b110, "bp write");
            chk($sformatf("bp af w%0d", j), 48'(in_almost_full[1]), 48'(exp_af[j]));
            chk($sformatf("bp full w%0d", j), 48'(in_full[1]), 48'(exp_full[j]));
        end
        chk("bp held flit", {31'h0, out_valid[0], out_data[15:0]}, {31'h0, 1'b1, 16'h1001});
        for (int j = 0; j < 4; j++) begin
            step(0, 3'b000, 48'h0, 3'b111, "bp drain");
            f = 16'((j + 2) << 12) | 16'h0001;
            chk($sformatf("bp drain %0d", j), {31'h0, out_valid[0], out_data[15:0]},
                {31'h0, 1'b1, f});
        end
        step(0, 3'b000, 48'h0, 3'b111, "bp end");
        chk("bp end valid", 48'(out_valid[0]), 48'h0);

        // Reset in the middle of traffic, with writes presented during the reset edge.
        for (int j = 0; j < 3; j++) begin
            step(0, 3'b011, {16'h0, 16'h7101 + 16'(j), 16'h7001 + 16'(j)}, 3'b110, "rst fill");
        end
        step(1, 3'b111, {16'h0005, 16'h0003, 16'h0001}, 3'b111, "rst edge");
        chk("rst out_valid", 48'(out_valid), 48'h0);
        chk("rst in_full", 48'(in_full), 48'h0);
        chk("rst in_almost_full", 48'(in_almost_full), 48'h0);
        chk("rst out_data", out_data, 48'h0);
        for (int j = 0; j < 8; j++) begin
            step(0, 3'b000, 48'h0, 3'b111, "rst drain");
            chk($sformatf("rst no flit %0d", j), 48'(out_valid), 48'h0);
        end

        // Random traffic against the model.
        for (int j = 0; j < 600; j++) begin
            for (int p = 0; p < 3; p++) begin
                f = 16'($urandom);
                f[0] = ($urandom_range(0, 7) != 0);
                d[p*16 +: 16] = f;
            end
            step(($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)), d,
                 3'($urandom_range(0, 7)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/noc_router_rr.md
NOC_ROUTER_RR -- requirements
Module: noc_router_rr

Interface
REQ-001 Parameter NUM_PORTS, default 3: number of bidirectional ports, range 2..8.
REQ-002 Parameter DATA_W, default 16: flit width in bits, minimum 1+DEST_W.
REQ-003 Parameter FIFO_DEPTH, default 4: input FIFO entries per port, power of two, minimum 2.
REQ-004 Parameter AF_LEVEL, default 1: in_almost_full asserts when free entries <= AF_LEVEL.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 Port in_valid, input, NUM_PORTS bits: per-port write strobe.
REQ-008 Port in_data, input, NUM_PORTS*DATA_W bits: per-port flit; port p occupies bits [p*DATA_W +: DATA_W].
REQ-009 Port in_full, output, NUM_PORTS bits: the input FIFO holds FIFO_DEPTH entries.
REQ-010 Port in_almost_full, output, NUM_PORTS bits: per REQ-004.
REQ-011 Port out_valid, output, NUM_PORTS bits: the output register holds a flit.
REQ-012 Port out_data, output, NUM_PORTS*DATA_W bits: registered output flit, packed as in REQ-008.
REQ-013 Port out_ready, input, NUM_PORTS bits: the downstream consumer takes the flit this cycle.
REQ-014 Port bad_dest, output, NUM_PORTS bits: one-cycle pulse when a head flit addresses a nonexistent port.

Function
REQ-015 Flit format: bit 0 is valid; bits [DEST_W:1] are the destination port index; DEST_W = clog2(NUM_PORTS), minimum 1.
REQ-016 Write: in_valid[p] and not in_full[p] enqueues in_data[p]; a write while full is ignored, with no state change.
REQ-017 in_full and in_almost_full derive from the registered count only; a pop in the same cycle does not admit a write to a full FIFO.
REQ-018 No FIFO bypass: a flit written at edge k can first be arbitrated in the cycle after edge k.
REQ-019 Head flit with bit 0 = 0: popped next edge, no output, no arbitration slot used.
REQ-020 Head flit with dest >= NUM_PORTS: popped, bad_dest[p] pulses for exactly 1 cycle, no output.
REQ-021 Output o is free when out_valid[o]=0 or out_ready[o]=1.
REQ-022 Output o, when free, grants one requesting input (valid head, dest=o) by round-robin: search begins at rr_ptr[o].
REQ-023 On a grant to input i: rr_ptr[o] <= (i+1) mod NUM_PORTS; no grant leaves rr_ptr[o] unchanged.
REQ-024 On a grant: head popped, out_data[o] loaded, out_valid[o]=1 at the same edge; uncontended latency is write at edge k, out_valid after edge k+1.
REQ-025 Free output with no grant: out_valid[o] <= 0 and out_data[o] holds its value.
REQ-026 A blocked head affects only its own FIFO; other inputs to other outputs proceed in the same cycle.
REQ-027 At most one pop per FIFO per cycle; simultaneous push and pop on a non-full FIFO leaves count unchanged; pointers wrap mod FIFO_DEPTH.

Reset
REQ-028 While reset=1 at an edge: all FIFOs empty, rr_ptr = 0, out_valid = 0, out_data = 0, bad_dest = 0, in_full = 0, in_almost_full = 0 (AF_LEVEL < FIFO_DEPTH).
REQ-029 Reset overrides any same-cycle write, pop or grant; all queued flits are discarded.

Structure
REQ-030 Package noc_pkg holds the flit field constants (VALID_BIT=0, DEST_LSB=1) and the clog2 function.
REQ-031 One sub-module, noc_fifo (parameters DATA_W, FIFO_DEPTH, AF_LEVEL), is instantiated once per port.
REQ-032 Round-robin arbitration and the output registers live in noc_router_rr.

Verification (NUM_PORTS=3, DATA_W=16, FIFO_DEPTH=4, AF_LEVEL=1)
REQ-033 Single flit: in_data[0]=16'h0003 at edge k, out_ready=3'b111 -> after edge k+1, out_valid=3'b010 and out_data[1]=16'h0003; after edge k+2, out_valid=0.
REQ-034 Contention: 16'h0005, 16'h0105, 16'h0205 on ports 0, 1, 2 at one edge -> out_data[2] is 0005, 0105, 0205 on three consecutive cycles; rr_ptr[2] ends at 0.
REQ-035 Backpressure: out_ready[0]=0, port 1 writes six flits dest 0 -> in_almost_full[1] asserts at FIFO count 3; in_full[1] asserts at count 4; sixth write dropped; out_ready[0]=1 -> five flits emerge in order, back-to-back.
REQ-036 Discards: 16'h0002 on port 0 -> no output; 16'h0007 on port 2 -> bad_dest=3'b100 for one cycle, no output.
REQ-037 HOL isolation: port 0 blocked to output 0 (out_ready[0]=0) while port 1 sends 16'h0005 -> out_data[2]=16'h0005 with the uncontended latency of REQ-024.
REQ-038 Mid-traffic reset: with FIFOs partly full, reset for one edge -> next cycle out_valid=0, in_full=0; no queued flit ever appears.
